// File: rtl/nn_pkg.sv
// Shared constants and state type for the neuron MAC and the sigmoid stage.
package nn_pkg;

  localparam int unsigned DOUT_W    = 22;
  localparam int unsigned DOUT_FRAC = 14;
  localparam int unsigned ACT_W     = 8;
  localparam int unsigned WGT_W     = 8;
  localparam int unsigned PROD_W    = 17;

  localparam logic [DOUT_W-1:0] SAT_POS = 22'h1FFFFF;
  localparam logic [DOUT_W-1:0] SAT_NEG = 22'h200000;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    DRAIN,
    SAT,
    OUT
  } state_e;

endpackage

// File: rtl/neuron_mac_if.sv
// Beat stream in, pre-activation word out, plus control/status of one neuron.
interface neuron_mac_if;
  import nn_pkg::*;

  logic              start;
  logic [DOUT_W-1:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic [ACT_W-1:0]  act;
  logic [WGT_W-1:0]  wgt;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dout;
  logic              busy;

  // Driver of beats and consumer of the result.
  modport master (
    output start, bias, in_valid, act, wgt, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  // The neuron itself.
  modport slave (
    input  start, bias, in_valid, act, wgt, out_ready,
    output in_ready, out_valid, dout, busy
  );

endinterface

// File: rtl/neuron_sat.sv
// Combinational signed saturator from an ACC_W accumulator to a 22-bit Q7.14 word.
module neuron_sat
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W = 26
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DOUT_W-1:0] sat
);

  // In range iff every bit above the result sign matches the accumulator sign.
  always_comb begin
    sat = acc[DOUT_W-1:0];
    if (acc[ACC_W-1:DOUT_W-1] != {(ACC_W-DOUT_W+1){acc[ACC_W-1]}}) begin
      sat = acc[ACC_W-1] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron: N_IN beats + bias -> one saturated Q7.14 word.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned ACC_W = 26,
  parameter int unsigned CNT_W = 10
) (
  input logic         clk,
  input logic         rst_n,
  neuron_mac_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic                pv_q, pv_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DOUT_W-1:0]   dout_q, dout_d;
  logic                ov_q, ov_d;
  logic [DOUT_W-1:0]   sat_val;
  logic [PROD_W-1:0]   act_ext, wgt_ext, prod;
  logic                hs;

  // Unsigned activation times signed weight; the product fits 17 bits exactly.
  assign act_ext = {{(PROD_W-ACT_W){1'b0}}, bus.act};
  assign wgt_ext = {{(PROD_W-WGT_W){bus.wgt[WGT_W-1]}}, bus.wgt};
  assign prod    = act_ext * wgt_ext;

  assign hs = bus.in_valid && (state_q == ACC);

  neuron_sat #(
    .ACC_W(ACC_W)
  ) u_sat (
    .acc(acc_q),
    .sat(sat_val)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    pv_d    = 1'b0;
    acc_d   = acc_q;
    dout_d  = dout_q;
    ov_d    = ov_q;
    // Product registered last cycle is folded in one cycle later.
    if (pv_q) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
    end
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = {{(ACC_W-DOUT_W){bus.bias[DOUT_W-1]}}, bus.bias};
          count_d = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (hs) begin
          p_d     = prod;
          pv_d    = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = SAT;
      SAT: begin
        dout_d  = sat_val;
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      p_q     <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = ov_q;
  assign bus.dout      = dout_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: a 4-beat instance and a full 784-beat instance.
module tb_neuron_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  neuron_mac_if bus4 ();
  neuron_mac_if bus784 ();

  neuron_mac #(.N_IN(4), .ACC_W(26), .CNT_W(10)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  neuron_mac #(.N_IN(784), .ACC_W(26), .CNT_W(10)) dut784 (
    .clk(clk), .rst_n(rst_n), .bus(bus784)
  );

  int          checks = 0;
  int          errors = 0;
  logic [21:0] q4[$];
  logic [21:0] q784[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [21:0] sat_ref(input longint s);
    if (s > 64'sd2097151) return 22'h1FFFFF;
    if (s < -64'sd2097152) return 22'h200000;
    return s[21:0];
  endfunction

  // Reference: bias plus plain integer sum of act*wgt, then clamp.
  function automatic logic [21:0] model4(input logic [21:0] b, input logic [7:0] a[4],
                                         input logic [7:0] w[4]);
    longint s;
    s = longint'($signed(b));
    for (int i = 0; i < 4; i++) s += longint'(a[i]) * longint'($signed(w[i]));
    return sat_ref(s);
  endfunction

  // Monitor for the 4-beat instance: scoreboard pops plus stall stability.
  logic        stall_prev = 1'b0;
  logic [21:0] prev_dout = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", bus4.out_valid, 1);
        check("stall_dout_held", bus4.dout, prev_dout);
      end
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) check("unexpected_result4", 1, 0);
        else check("dout4", bus4.dout, q4.pop_front());
      end
      stall_prev = bus4.out_valid && !bus4.out_ready;
      prev_dout  = bus4.dout;
    end
  end

  // Monitor for the 784-beat instance.
  always @(negedge clk) begin
    if (rst_n && bus784.out_valid && bus784.out_ready) begin
      if (q784.size() == 0) check("unexpected_result784", 1, 0);
      else check("dout784", bus784.dout, q784.pop_front());
    end
  end

  // gap_mode: 0 dense, 1 alternate, 2 random bubbles. stall: cycles out_ready held low.
  task automatic run4(input logic [21:0] b, input logic [7:0] a[4], input logic [7:0] w[4],
                      input int gap_mode, input int stall, input bit restart);
    int i, k, last_c, wait_c;
    bit seen;
    q4.push_back(model4(b, a, w));
    bus4.out_ready = (stall == 0);
    bus4.start = 1'b1;
    bus4.bias  = b;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    i = 0; k = 0; last_c = 0;
    while (i < 4 && k < 200) begin
      case (gap_mode)
        0:       bus4.in_valid = 1'b1;
        1:       bus4.in_valid = (k % 2 == 0);
        default: bus4.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus4.act   = a[i];
      bus4.wgt   = w[i];
      bus4.start = restart && (k == 1);
      @(negedge clk);
      if (bus4.in_valid && bus4.in_ready) begin
        if (i == 3) last_c = cyc;
        i++;
      end
      @(posedge clk); #1;
      k++;
    end
    bus4.in_valid = 1'b0;
    bus4.start    = 1'b0;
    check("beats4", i, 4);
    seen = 1'b0; wait_c = 0;
    while (!seen && wait_c < 20) begin
      @(negedge clk);
      if (bus4.out_valid) seen = 1'b1;
      else wait_c++;
    end
    check("out_valid_seen", seen, 1);
    if (seen) begin
      check("latency", cyc - last_c, 3);
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        @(posedge clk); #1;
        bus4.out_ready = 1'b1;
        @(negedge clk);
      end
      @(negedge clk);
      check("idle_after_out", {bus4.busy, bus4.out_valid}, 0);
    end
  endtask

  task automatic run784(input logic [7:0] w);
    int n, k, wait_c;
    q784.push_back(sat_ref(longint'(784) * 255 * longint'($signed(w))));
    bus784.start = 1'b1;
    bus784.bias  = '0;
    @(posedge clk); #1;
    bus784.start    = 1'b0;
    bus784.in_valid = 1'b1;
    bus784.act      = 8'd255;
    bus784.wgt      = w;
    n = 0; k = 0;
    while (n < 784 && k < 2000) begin
      @(negedge clk);
      if (bus784.in_valid && bus784.in_ready) n++;
      @(posedge clk); #1;
      k++;
    end
    bus784.in_valid = 1'b0;
    check("beats784", n, 784);
    wait_c = 0;
    while (q784.size() != 0 && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    check("drain784", q784.size(), 0);
  endtask

  logic [7:0]  a[4];
  logic [7:0]  w[4];
  logic [21:0] b;

  initial begin
    bus4.start = 0; bus4.bias = 0; bus4.in_valid = 0; bus4.act = 0; bus4.wgt = 0;
    bus4.out_ready = 0;
    bus784.start = 0; bus784.bias = 0; bus784.in_valid = 0; bus784.act = 0; bus784.wgt = 0;
    bus784.out_ready = 1;

    repeat (3) @(negedge clk);
    check("reset_flags4", {bus4.in_ready, bus4.out_valid, bus4.busy}, 0);
    check("reset_dout4", bus4.dout, 0);
    check("reset_flags784", {bus784.in_ready, bus784.out_valid, bus784.busy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unity weight, full activation.
    a = '{8'd255, 8'd255, 8'd255, 8'd255};
    w = '{8'h40, 8'h40, 8'h40, 8'h40};
    run4(22'h0, a, w, 0, 0, 1'b0);
    // Most negative weight.
    w = '{8'h80, 8'h80, 8'h80, 8'h80};
    run4(22'h0, a, w, 0, 0, 1'b0);
    // Bubbles every other cycle and a 5-cycle consumer stall.
    w = '{8'h40, 8'h40, 8'h40, 8'h40};
    run4(22'h0, a, w, 1, 5, 1'b0);
    // Negative bias only, with a stray start during accumulation.
    a = '{8'd0, 8'd0, 8'd0, 8'd0};
    run4(22'h3FC000, a, w, 0, 0, 1'b1);
    repeat (10) @(negedge clk);
    check("single_result", q4.size(), 0);

    // Abort after two beats.
    bus4.out_ready = 1'b0;
    bus4.start = 1'b1; bus4.bias = 22'h012345;
    @(posedge clk); #1;
    bus4.start = 1'b0; bus4.in_valid = 1'b1; bus4.act = 8'd255; bus4.wgt = 8'h40;
    repeat (2) @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_flags", {bus4.in_ready, bus4.out_valid, bus4.busy}, 0);
    check("abort_dout", bus4.dout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    w = '{8'h7F, 8'h80, 8'h12, 8'hC3};
    run4(22'h000100, a, w, 0, 0, 1'b0);

    // Saturation edges driven by bias.
    a = '{8'd255, 8'd255, 8'd255, 8'd255};
    w = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    run4(22'h1F0000, a, w, 0, 0, 1'b0);
    w = '{8'h80, 8'h80, 8'h80, 8'h80};
    run4(22'h210000, a, w, 0, 1, 1'b0);
    a = '{8'd0, 8'd0, 8'd0, 8'd0};
    run4(22'h1FFFFF, a, w, 0, 0, 1'b0);

    // Randomised runs.
    for (int r = 0; r < 30; r++) begin
      b = 22'($urandom);
      for (int i = 0; i < 4; i++) begin
        a[i] = 8'($urandom);
        w[i] = 8'($urandom);
      end
      run4(b, a, w, 2, int'($urandom_range(0, 3)), 1'b0);
    end

    // Full-length evaluation into both clamps.
    run784(8'h7F);
    run784(8'h80);

    repeat (5) @(negedge clk);
    check("q4_empty", q4.size(), 0);
    check("q784_empty", q784.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
